// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and sizing helpers for the bit-serial subtractor
package serial_subtractor_pkg;

  // Code 2'd3 is never entered; the FSM treats it like IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full subtractor (a - b - bin)
module serial_subtractor_full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial WIDTH-bit subtractor with start/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             bout_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] acc_d;

  serial_subtractor_full_subtractor u_fs (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .bin_i (br_q),
    .d_o   (bit_d),
    .bout_o(br_d)
  );

  // Partial result fills from the MSB so the last bit lands the word in place.
  always_comb begin
    acc_d            = acc_q >> 1;
    acc_d[WIDTH-1]   = bit_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= br_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= S_DONE;
            diff_q  <= acc_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE chains straight into RUN.
          if (start_i) begin
            state_q <= S_RUN;
            a_sh_q  <= a_i;
            b_sh_q  <= b_i;
            br_q    <= bin_i;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign diff_o  = diff_q;
  assign bout_o  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and swept checks of serial_subtractor at WIDTH=4 and WIDTH=16
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, bin;
  logic [3:0]  a, b;
  logic        ready, busy, done, bout;
  logic [3:0]  diff;
  logic        start16, bin16;
  logic [15:0] a16, b16;
  logic        ready16, busy16, done16, bout16;
  logic [15:0] diff16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .bin_i(bin),
    .ready_o(ready), .busy_o(busy), .done_o(done), .diff_o(diff), .bout_o(bout)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .a_i(a16), .b_i(b16), .bin_i(bin16),
    .ready_o(ready16), .busy_o(busy16), .done_o(done16), .diff_o(diff16), .bout_o(bout16)
  );

  always @(posedge clk) begin
    if (!rst && ready)
      assert (!$isunknown(start)) else begin
        errors++;
        $error("FAIL start_x: observed %b expected 0/1", start);
      end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic op4(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                     input logic bini, input logic [4:0] exp);
    int n;
    a = ai; b = bi; bin = bini; start = 1'b1;
    check({tag, "_ready"}, ready, 1'b1);
    @(negedge clk);
    start = 1'b0; a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 5);
    check({tag, "_res"}, {bout, diff}, exp);
  endtask

  task automatic op16(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                      input logic bini, input logic [16:0] exp);
    int n;
    a16 = ai; b16 = bi; bin16 = bini; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    n = 1;
    while (!done16 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 17);
    check({tag, "_res"}, {bout16, diff16}, exp);
  endtask

  initial begin
    int pulses, last, unstable, n;
    logic [4:0]  got;
    logic [3:0]  av, bv;
    logic        cv;
    logic [31:0] x, y;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 4'h0);
    check("rst_bout", bout, 1'b0);
    check("rst_ready16", ready16, 1'b1);
    rst = 1'b0;

    op4("t1", 4'ha, 4'h0, 1'b1, 5'h09);
    op4("t2a", 4'h0, 4'h8, 1'b0, 5'h18);
    op4("t2b", 4'h1, 4'h1, 1'b1, 5'h1f);
    @(negedge clk);
    check("t2_one_pulse", done, 1'b0);
    check("t2_hold_idle", {bout, diff}, 5'h1f);
    op4("eq", 4'h9, 4'h9, 1'b0, 5'h00);
    op4("wrap", 4'h0, 4'h0, 1'b1, 5'h1f);

    // T3: start pulses during RUN must not disturb the operation in flight
    a = 4'h7; b = 4'h3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; got = '0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) begin start = 1'b1; a = 4'hf; b = 4'h0; end
      if (i == 3) start = 1'b0;
      if (i == 2) check("t3_hold_run", {bout, diff}, 5'h1f);
      if (done) begin pulses++; got = {bout, diff}; end
      @(negedge clk);
    end
    check("t3_pulses", pulses, 1);
    check("t3_res", got, 5'h04);

    // T4: reset in the third RUN cycle, with start asserted alongside it
    a = 4'h5; b = 4'h2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("t4_ready", ready, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_done", done, 1'b0);
    check("t4_res", {bout, diff}, 5'h00);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("t4_no_activity", pulses, 0);
    op4("t4_fresh", 4'h1, 4'h0, 1'b0, 5'h01);

    // T5: start held high gives a result every WIDTH+1 cycles
    a = 4'h6; b = 4'h2; bin = 1'b1; start = 1'b1;
    pulses = 0; last = 0; unstable = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (done) begin
        if (pulses > 0) check("t5_interval", i - last, 5);
        check("t5_res", {bout, diff}, 5'h03);
        last = i;
        pulses++;
      end
      if (pulses > 0 && {bout, diff} !== 5'h03) unstable++;
    end
    start = 1'b0;
    check("t5_pulses", pulses, 3);
    check("t5_stable", unstable, 0);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_drain", done, 1'b1);

    // T6: exhaustive WIDTH=4 sweep
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          av = 4'(ai); bv = 4'(bi); cv = 1'(ci);
          op4("t6", av, bv, cv, {1'b0, av} - {1'b0, bv} - {4'b0, cv});
        end
      end
    end

    op16("w16_wrap", 16'h0000, 16'h0000, 1'b1, 17'h1ffff);
    op16("w16_eq", 16'hffff, 16'hffff, 1'b0, 17'h00000);
    op16("w16_dir", 16'h1234, 16'h0235, 1'b1, 17'h00ffe);
    repeat (300) begin
      x = $urandom; y = $urandom; cv = 1'($urandom);
      op16("w16_rand", x[15:0], y[15:0], cv, {1'b0, x[15:0]} - {1'b0, y[15:0]} - {16'b0, cv});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
